// File: rtl/bcd_conv_scheduler.sv
// bcd_conv_scheduler: round-robin shared serial binary-to-BCD (double-dabble) engine
// Ports:
//   i_clk, i_rst_n     clock (rising edge), asynchronous active-low reset
//   i_req[NUM_CH]      level requests, held until o_ack
//   i_data             channel c sample at [c*WIDTH +: WIDTH]
//   o_ack[NUM_CH]      one-cycle pulse when channel c's sample is captured
//   o_bcd              channel c result at [c*DIGITS*4 +: DIGITS*4], digit 0 in LSBs
//   o_done[NUM_CH]     one-cycle pulse when slot c has just been written
//   o_valid[NUM_CH]    sticky: slot c holds at least one completed result
//   o_busy             engine converting or finishing
module bcd_conv_scheduler #(
  parameter int NUM_CH = 3,
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic [NUM_CH-1:0]            i_req,
  input  logic [NUM_CH*WIDTH-1:0]      i_data,
  output logic [NUM_CH-1:0]            o_ack,
  output logic [NUM_CH*DIGITS*4-1:0]   o_bcd,
  output logic [NUM_CH-1:0]            o_done,
  output logic [NUM_CH-1:0]            o_valid,
  output logic                         o_busy
);
  localparam int PW = $clog2(NUM_CH);
  localparam int CW = $clog2(WIDTH);
  localparam int AW = DIGITS * 4;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                   r_state, w_next;
  logic [PW-1:0]            r_ptr, r_grant, w_gnt;
  logic [WIDTH-1:0]         r_bin;
  logic [AW-1:0]            r_acc, w_adj, w_shift;
  logic [CW-1:0]            r_cnt;
  logic [NUM_CH-1:0]        r_ack, r_done, r_valid;
  logic [NUM_CH*AW-1:0]     r_bcd;
  logic                     r_busy, w_any, w_last, w_start;

  assign w_any   = |i_req;
  assign w_start = (r_state == IDLE) && w_any;
  assign w_last  = r_cnt == CW'(WIDTH - 1);

  // Scan downward so the nearest requester at or after the pointer wins.
  always_comb begin
    w_gnt = '0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (i_req[PW'((int'(r_ptr) + i) % NUM_CH)]) w_gnt = PW'((int'(r_ptr) + i) % NUM_CH);
  end

  always_comb begin
    w_adj = r_acc;
    for (int d = 0; d < DIGITS; d++)
      w_adj[d*4 +: 4] = r_acc[d*4 +: 4] > 4'd4 ? r_acc[d*4 +: 4] + 4'd3 : r_acc[d*4 +: 4];
  end

  assign w_shift = {w_adj[AW-2:0], r_bin[WIDTH-1]};

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_next;

  always_comb begin
    w_next = r_state;
    if (w_start)                       w_next = SHIFT;
    if (r_state == SHIFT && w_last)    w_next = DONE;
    if (r_state == DONE)               w_next = IDLE;
  end

  // The final iteration writes its shifted result straight into the slot, so
  // o_done is visible during the DONE cycle and the next grant follows it.
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_ptr   <= '0;
      r_grant <= '0;
      r_bin   <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_ack   <= '0;
      r_done  <= '0;
      r_valid <= '0;
      r_bcd   <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_ack  <= '0;
      r_done <= '0;
      r_busy <= w_next != IDLE;
      if (w_start) begin
        r_grant <= w_gnt;
        r_bin   <= i_data[int'(w_gnt)*WIDTH +: WIDTH];
        r_acc   <= '0;
        r_cnt   <= '0;
        r_ack   <= NUM_CH'(1) << w_gnt;
      end
      if (r_state == SHIFT) begin
        r_acc <= w_shift;
        r_bin <= r_bin << 1;
        r_cnt <= r_cnt + CW'(1);
        if (w_last) begin
          r_bcd[int'(r_grant)*AW +: AW] <= w_shift;
          r_done                        <= NUM_CH'(1) << r_grant;
          r_valid[r_grant]              <= 1'b1;
        end
      end
      if (r_state == DONE) r_ptr <= r_grant == PW'(NUM_CH - 1) ? '0 : r_grant + PW'(1);
    end

  assign o_ack   = r_ack;
  assign o_done  = r_done;
  assign o_valid = r_valid;
  assign o_bcd   = r_bcd;
  assign o_busy  = r_busy;
endmodule

// File: tb/tb_bcd_conv_scheduler.sv
// tb_bcd_conv_scheduler: directed + random checks of the shared BCD scheduler against an arithmetic model
module tb_bcd_conv_scheduler;
  localparam int NCH = 3;
  localparam int W   = 16;
  localparam int AW  = 20;

  logic                i_clk = 1'b0;
  logic                i_rst_n;
  logic [NCH-1:0]      i_req;
  logic [NCH*W-1:0]    i_data;
  logic [NCH-1:0]      o_ack, o_done, o_valid;
  logic [NCH*AW-1:0]   o_bcd;
  logic                o_busy;

  int                  vecs = 0, errs = 0, cyc_n = 0, ack_cyc = 0, pend_ch = -1;
  logic [W-1:0]        pend_val;
  logic [AW-1:0]       exp_bcd [NCH];
  logic [NCH-1:0]      exp_valid;

  bcd_conv_scheduler dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_req(i_req), .i_data(i_data),
    .o_ack(o_ack), .o_bcd(o_bcd), .o_done(o_done), .o_valid(o_valid), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [AW-1:0] bcd(input int unsigned x);
    logic [AW-1:0] r = '0;
    int unsigned p = 1;
    for (int d = 0; d < 5; d++) begin
      r[d*4 +: 4] = 4'((x / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  function automatic logic [NCH*AW-1:0] mbcd();
    logic [NCH*AW-1:0] r = '0;
    for (int c = 0; c < NCH; c++) r[c*AW +: AW] = exp_bcd[c];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge i_clk); #1;
    cyc_n++;
    if (o_done != 0) begin
      chk("done_ch", o_done, pend_ch < 0 ? 64'd0 : 64'(1) << pend_ch);
      chk("done_lat", 64'(cyc_n - ack_cyc), 64'd16);
      if (pend_ch >= 0) begin
        exp_bcd[pend_ch]   = bcd(pend_val);
        exp_valid[pend_ch] = 1'b1;
      end
      pend_ch = -1;
      chk("bcd_done", o_bcd, mbcd());
      chk("valid", o_valid, exp_valid);
    end else chk("bcd_hold", o_bcd, mbcd());
  endtask

  task automatic wait_ack(input int ch, input int gap, input bit keep);
    int n = 0;
    do begin cyc(); n++; end while (o_ack == 0 && n < 60);
    chk("ack_gap", 64'(n), 64'(gap));
    chk("ack_ch", o_ack, 64'(1) << ch);
    chk("busy_ack", o_busy, 1);
    pend_ch  = ch;
    pend_val = i_data[ch*W +: W];
    ack_cyc  = cyc_n;
    if (!keep) begin
      i_req[ch]          = 1'b0;
      i_data[ch*W +: W]  = 16'($urandom);
    end
  endtask

  task automatic wait_done();
    int n = 0;
    while (pend_ch >= 0 && n < 40) begin cyc(); n++; end
    chk("done_seen", 64'(pend_ch + 1), 64'd0);
    cyc();
    chk("busy_idle", o_busy, 0);
  endtask

  task automatic go(input int ch, input logic [W-1:0] d);
    i_data[ch*W +: W] = d;
    i_req[ch]         = 1'b1;
    wait_ack(ch, 1, 1'b0);
    wait_done();
  endtask

  initial begin
    int ch;
    logic [W-1:0] d;
    i_rst_n = 1'b0;
    i_req   = '0;
    i_data  = '0;
    exp_valid = '0;
    for (int c = 0; c < NCH; c++) exp_bcd[c] = '0;
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_bcd", o_bcd, 0);
    chk("rst_valid", o_valid, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_ack", o_ack, 0);
    chk("rst_done", o_done, 0);
    i_rst_n = 1'b1;

    go(0, 16'h3039);
    chk("ch0_12345", o_bcd[19:0], 20'h12345);
    chk("ch0_valid", o_valid, 3'b001);
    chk("ch0_others", o_bcd[59:20], 0);

    go(1, 16'hFFFF);
    chk("ch1_max", o_bcd[39:20], 20'h65535);
    go(1, 16'h0000);
    chk("ch1_zero", o_bcd[39:20], 20'h00000);
    chk("ch1_valid", o_valid[1], 1);

    go(2, 16'h270F);
    chk("ch2_9999", o_bcd[59:40], 20'h09999);
    go(2, 16'h0001);
    chk("ch2_one", o_bcd[59:40], 20'h00001);

    i_data = {16'($urandom), 16'($urandom), 16'($urandom)};
    i_req  = 3'b111;
    wait_ack(0, 1, 1'b0);
    wait_ack(1, 18, 1'b0);
    wait_ack(2, 18, 1'b0);
    wait_done();

    i_data[0 +: W] = 16'($urandom);
    i_req[0] = 1'b1;
    wait_ack(0, 1, 1'b1);
    i_data[W +: W] = 16'($urandom);
    i_req[1] = 1'b1;
    wait_ack(1, 18, 1'b0);
    wait_ack(0, 18, 1'b1);
    i_req[0] = 1'b0;
    wait_done();

    i_data[0 +: W] = 16'($urandom);
    i_req[0] = 1'b1;
    wait_ack(0, 1, 1'b0);
    repeat (8) cyc();
    #1 i_rst_n = 1'b0;
    #1;
    chk("abort_bcd", o_bcd, 0);
    chk("abort_valid", o_valid, 0);
    chk("abort_busy", o_busy, 0);
    @(posedge i_clk); #1;
    chk("abort_done", o_done, 0);
    chk("abort_busy2", o_busy, 0);
    #2 i_rst_n = 1'b1;
    pend_ch   = -1;
    exp_valid = '0;
    for (int c = 0; c < NCH; c++) exp_bcd[c] = '0;
    go(0, 16'h3039);
    chk("post_rst", o_bcd[19:0], 20'h12345);

    repeat (25) begin
      ch = $urandom_range(0, NCH - 1);
      d  = ($urandom_range(0, 4) == 0) ? 16'hFFFF : 16'($urandom);
      go(ch, d);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
